// File: rtl/demux_1_8_rr_scheduler_if.sv
// Signal bundle between the round-robin scheduler, its upstream source and the 1-to-8 demux.
// The scheduler takes the slave modport; the upstream/destination side takes the master modport.
interface demux_1_8_rr_scheduler_if #(
    parameter int DATA_W = 8
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [7:0]        i_dest_en;
    logic [7:0]        i_dest_ready;
    logic              o_a;
    logic [7:0]        o_sel_code;
    logic [DATA_W-1:0] o_data;
    logic [2:0]        o_cur_dest;
    logic              o_skip;

    modport slave (
        input  i_valid, i_data, i_dest_en, i_dest_ready,
        output o_ready, o_a, o_sel_code, o_data, o_cur_dest, o_skip
    );

    modport master (
        output i_valid, i_data, i_dest_en, i_dest_ready,
        input  o_ready, o_a, o_sel_code, o_data, o_cur_dest, o_skip
    );
endinterface

// File: rtl/demux_1_8_rr_scheduler.sv
// Round-robin scheduler for a 1-to-8 demux: buffers one upstream word and offers it to the
// next enabled destination after the last one served, skipping a destination that stalls too long.
module demux_1_8_rr_scheduler #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    demux_1_8_rr_scheduler_if.slave bus
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              ready_q, ready_d;
    logic              a_q, a_d;
    logic [7:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        cur_q, cur_d;
    logic              skip_q, skip_d;

    logic       accept;
    logic       curEn;
    logic       curRdy;
    logic       timeoutHit;
    logic       pickValid;
    logic [2:0] pickIdx;

    assign accept     = (state_q == IDLE) && ready_q && bus.i_valid;
    assign curEn      = bus.i_dest_en[cur_q];
    assign curRdy     = bus.i_dest_ready[cur_q];
    assign timeoutHit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    // Scan ptr+1 .. ptr+8 (the last step lands back on ptr, so a lone destination is re-picked).
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            if (!pickValid && bus.i_dest_en[3'(ptr_q + 3'(i))]) begin
                pickValid = 1'b1;
                pickIdx   = 3'(ptr_q + 3'(i));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd7;
            timer_q <= '0;
            ready_q <= 1'b0;
            a_q     <= 1'b0;
            sel_q   <= 8'h00;
            data_q  <= '0;
            cur_q   <= 3'd0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            ready_q <= ready_d;
            a_q     <= a_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            cur_q   <= cur_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = ARB;
            ARB:  if (pickValid) state_d = SEND;
            SEND: begin
                if (!curEn)          state_d = ARB;
                else if (curRdy)     state_d = IDLE;
                else if (timeoutHit) state_d = ARB;
            end
            default: state_d = IDLE;
        endcase
    end

    // Priority in SEND: disabled destination, then completion, then timeout, then keep waiting.
    always_comb begin
        ptr_d   = ptr_q;
        timer_d = timer_q;
        a_d     = a_q;
        sel_d   = sel_q;
        data_d  = data_q;
        cur_d   = cur_q;
        skip_d  = 1'b0;
        ready_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept) data_d = bus.i_data;
            end
            ARB: begin
                if (pickValid) begin
                    cur_d   = pickIdx;
                    sel_d   = 8'h01 << pickIdx;
                    a_d     = 1'b1;
                    timer_d = '0;
                end else begin
                    a_d   = 1'b0;
                    sel_d = 8'h00;
                end
            end
            SEND: begin
                if (!curEn) begin
                    a_d   = 1'b0;
                    sel_d = 8'h00;
                end else if (curRdy) begin
                    ptr_d = cur_q;
                    a_d   = 1'b0;
                    sel_d = 8'h00;
                end else if (timeoutHit) begin
                    skip_d = 1'b1;
                    ptr_d  = cur_q;
                    a_d    = 1'b0;
                    sel_d  = 8'h00;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_a        = a_q;
    assign bus.o_sel_code = sel_q;
    assign bus.o_data     = data_q;
    assign bus.o_cur_dest = cur_q;
    assign bus.o_skip     = skip_q;
endmodule

// File: tb/tb_demux_1_8_rr_scheduler.sv
// Directed bench for the round-robin demux scheduler: inputs change and outputs are checked
// on the falling edge, so each check sees the state left by the preceding rising edge.
module tb_demux_1_8_rr_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   assertions = 0;
    int   failures   = 0;

    demux_1_8_rr_scheduler_if #(.DATA_W(8)) bus ();

    demux_1_8_rr_scheduler #(
        .DATA_W (8),
        .TIMEOUT(15)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                 input logic [7:0] en, input logic [7:0] rdy);
        bus.i_valid      = valid;
        bus.i_data       = data;
        bus.i_dest_en    = en;
        bus.i_dest_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic ready, input logic a,
                            input logic [7:0] sel, input logic [7:0] data,
                            input logic [2:0] cur, input logic skip);
        checkOutput({tag, ".ready"}, 32'(bus.o_ready), 32'(ready));
        checkOutput({tag, ".a"},     32'(bus.o_a), 32'(a));
        checkOutput({tag, ".sel"},   32'(bus.o_sel_code), 32'(sel));
        checkOutput({tag, ".data"},  32'(bus.o_data), 32'(data));
        checkOutput({tag, ".cur"},   32'(bus.o_cur_dest), 32'(cur));
        checkOutput({tag, ".skip"},  32'(bus.o_skip), 32'(skip));
    endtask

    // One word through accept / arbitrate / complete at full rate; expects o_ready=1 on entry.
    task automatic sendWord(input string tag, input logic [7:0] data, input logic [7:0] en,
                            input logic [7:0] rdy, input int expDest);
        checkOutput({tag, ".ready_in"}, 32'(bus.o_ready), 32'd1);
        applyStimulus(1'b1, data, en, rdy);
        tick();
        checkOutput({tag, ".ready_acc"}, 32'(bus.o_ready), 32'd0);
        checkOutput({tag, ".a_acc"}, 32'(bus.o_a), 32'd0);
        applyStimulus(1'b1, 8'hEE, en, rdy);
        tick();
        checkAll({tag, ".arb"}, 1'b0, 1'b1, 8'(1 << expDest), data, 3'(expDest), 1'b0);
        applyStimulus(1'b0, 8'h00, en, rdy);
        tick();
        checkAll({tag, ".done"}, 1'b1, 1'b0, 8'h00, data, 3'(expDest), 1'b0);
    endtask

    initial begin
        int t2Dest[4];
        t2Dest = '{2, 5, 2, 5};

        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        checkAll("reset", 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("reset.release_ready", 32'(bus.o_ready), 32'd1);

        $display("[TB] all destinations enabled, nine words");
        for (int k = 0; k < 9; k++)
            sendWord($sformatf("t1.w%0d", k), 8'(8'hA0 + k), 8'hFF, 8'hFF, k % 8);

        $display("[TB] destinations 2 and 5 only");
        for (int k = 0; k < 4; k++)
            sendWord($sformatf("t2.w%0d", k), 8'(8'hB0 + k), 8'b0010_0100, 8'hFF, t2Dest[k]);

        $display("[TB] timeout on destination 0");
        applyStimulus(1'b1, 8'hC0, 8'h03, 8'h02);
        tick();
        checkOutput("t3.accept_ready", 32'(bus.o_ready), 32'd0);
        applyStimulus(1'b0, 8'h00, 8'h03, 8'h02);
        for (int c = 1; c <= 15; c++) begin
            tick();
            checkAll($sformatf("t3.hold%0d", c), 1'b0, 1'b1, 8'h01, 8'hC0, 3'd0, 1'b0);
        end
        tick();
        checkAll("t3.skip", 1'b0, 1'b0, 8'h00, 8'hC0, 3'd0, 1'b1);
        tick();
        checkAll("t3.redirect", 1'b0, 1'b1, 8'h02, 8'hC0, 3'd1, 1'b0);
        tick();
        checkAll("t3.done", 1'b1, 1'b0, 8'h00, 8'hC0, 3'd1, 1'b0);

        $display("[TB] no destination enabled");
        applyStimulus(1'b1, 8'hD0, 8'h00, 8'hFF);
        tick();
        checkOutput("t4.accept_ready", 32'(bus.o_ready), 32'd0);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'hFF);
        for (int c = 1; c <= 3; c++) begin
            tick();
            checkAll($sformatf("t4.stall%0d", c), 1'b0, 1'b0, 8'h00, 8'hD0, 3'd1, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 8'h10, 8'hFF);
        tick();
        checkAll("t4.pick", 1'b0, 1'b1, 8'h10, 8'hD0, 3'd4, 1'b0);
        tick();
        checkAll("t4.done", 1'b1, 1'b0, 8'h00, 8'hD0, 3'd4, 1'b0);

        $display("[TB] reset during send");
        applyStimulus(1'b1, 8'hE0, 8'h08, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h08, 8'h00);
        tick();
        checkAll("t5.send", 1'b0, 1'b1, 8'h08, 8'hE0, 3'd3, 1'b0);
        tick();
        checkAll("t5.hold", 1'b0, 1'b1, 8'h08, 8'hE0, 3'd3, 1'b0);
        rst = 1'b1;
        tick();
        checkAll("t5.reset", 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'hFF, 8'hFF);
        tick();
        sendWord("t5.after", 8'hE1, 8'hFF, 8'hFF, 0);

        $display("[TB] destination disabled mid-send");
        sendWord("t6.prime", 8'hF0, 8'h80, 8'hFF, 7);
        applyStimulus(1'b1, 8'hF1, 8'h81, 8'h00);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h81, 8'h00);
        tick();
        checkAll("t6.send0", 1'b0, 1'b1, 8'h01, 8'hF1, 3'd0, 1'b0);
        tick();
        checkAll("t6.hold", 1'b0, 1'b1, 8'h01, 8'hF1, 3'd0, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h80, 8'h00);
        tick();
        checkAll("t6.drop", 1'b0, 1'b0, 8'h00, 8'hF1, 3'd0, 1'b0);
        tick();
        checkAll("t6.rearb", 1'b0, 1'b1, 8'h80, 8'hF1, 3'd7, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h80, 8'h80);
        tick();
        checkAll("t6.done", 1'b1, 1'b0, 8'h00, 8'hF1, 3'd7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
